// File: rtl/ppu_spr_eval_pkg.sv
// Shared definitions for the sprite evaluator: OAM field offsets, FSM states, sprite heights
// and the scanline/Y range test used by the compare stage.
package ppu_spr_eval_pkg;

  localparam int OAM_Y    = 0;
  localparam int OAM_TILE = 8;
  localparam int OAM_ATTR = 16;
  localparam int OAM_X    = 24;

  localparam logic [7:0] SPR_H8  = 8'd8;
  localparam logic [7:0] SPR_H16 = 8'd16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } eval_state_e;

  function automatic logic [8:0] spr_diff(input logic [7:0] scan, input logic [7:0] y);
    return {1'b0, scan} - {1'b0, y};
  endfunction

  // diff[8] set means the line is above the sprite; Y never wraps past 0xFF.
  function automatic logic spr_in_range(input logic [8:0] diff, input logic tall);
    return !diff[8] && (diff[7:0] < (tall ? SPR_H16 : SPR_H8));
  endfunction

endpackage

// File: rtl/ppu_spr_sec_oam.sv
// Secondary OAM: DEPTH x 32 register file, one write port, combinational read; latency 0 read / 1 write.
// Reads of an index >= DEPTH return 0; no backpressure.
module ppu_spr_sec_oam #(
  parameter int DEPTH = 8,
  parameter int IW    = 4
) (
  input  logic          i_ppu_clk,
  input  logic          i_ppu_rstn,
  input  logic          i_wr_en,
  input  logic [IW-1:0] i_wr_idx,
  input  logic [31:0]   i_wr_dat,
  input  logic [IW-1:0] i_rd_idx,
  output logic [31:0]   o_rd_dat
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
    if (!i_ppu_rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_wr_en && (i_wr_idx == IW'(i))) mem_q[i] <= i_wr_dat;
      end
    end
  end

  always_comb begin
    o_rd_dat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_rd_idx == IW'(i)) o_rd_dat = mem_q[i];
    end
  end

endmodule

// File: rtl/ppu_spr_eval.sv
// Per-scanline sprite evaluator: scans OAM one word per cycle, keeps the first SPR_PER_LINE hits.
// Start to done is OAM_ENTRIES+1 cycles; no backpressure, a new line-start aborts and restarts.
module ppu_spr_eval
  import ppu_spr_eval_pkg::*;
#(
  parameter int SPR_PER_LINE = 8,
  parameter int OAM_ENTRIES  = 64,
  parameter int OAM_AW       = 6,
  parameter int CW           = 4
) (
  input  logic              i_ppu_clk,
  input  logic              i_ppu_rstn,
  input  logic              i_line_start,
  input  logic [7:0]        i_scanline,
  input  logic              i_spr_8x16,
  input  logic              i_ovfl_clr,
  output logic [OAM_AW-1:0] o_oam_addr,
  input  logic [31:0]       i_oam_rdata,
  input  logic [CW-1:0]     i_sec_idx,
  output logic [31:0]       o_sec_rdata,
  output logic [CW-1:0]     o_sec_cnt,
  output logic              o_eval_busy,
  output logic              o_eval_done,
  output logic              o_spr0_line,
  output logic              o_spr_ovfl
);

  localparam logic [OAM_AW-1:0] ADDR_LAST = OAM_AW'(OAM_ENTRIES - 1);
  localparam logic [CW-1:0]     CNT_MAX   = CW'(SPR_PER_LINE);

  eval_state_e       state_q, state_d;
  logic [OAM_AW-1:0] addr_q, addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        scan_q, scan_d;
  logic              tall_q, tall_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic              cmp_first_q, cmp_first_d;
  logic              spr0_q, spr0_d;
  logic              ovfl_q, ovfl_d;
  logic              done_q, done_d;
  logic [8:0]        diff;
  logic              hit;
  logic              wr_en;
  logic [31:0]       wr_dat;

  // The word returned this cycle belongs to the address issued last cycle.
  assign diff   = spr_diff(scan_q, i_oam_rdata[OAM_Y +: 8]);
  assign hit    = cmp_vld_q && spr_in_range(diff, tall_q);
  assign wr_dat = {i_oam_rdata[OAM_X +: 8], i_oam_rdata[OAM_ATTR +: 8],
                   i_oam_rdata[OAM_TILE +: 8], 4'b0000, diff[3:0]};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    scan_d      = scan_q;
    tall_d      = tall_q;
    spr0_d      = spr0_q;
    ovfl_d      = ovfl_q;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    cmp_vld_d   = (state_q == ST_SCAN) && !i_line_start;
    cmp_first_d = (addr_q == '0);

    // Overflow from an in-flight compare survives both a clear and an abort.
    if (i_ovfl_clr) ovfl_d = 1'b0;
    if (hit && (cnt_q == CNT_MAX)) ovfl_d = 1'b1;

    if (i_line_start) begin
      state_d = ST_SCAN;
      addr_d  = '0;
      cnt_d   = '0;
      spr0_d  = 1'b0;
      scan_d  = i_scanline;
      tall_d  = i_spr_8x16;
    end else begin
      if (hit && (cnt_q != CNT_MAX)) begin
        wr_en = 1'b1;
        cnt_d = cnt_q + 1'b1;
      end
      if (hit && cmp_first_q) spr0_d = 1'b1;
      case (state_q)
        ST_SCAN: begin
          if (addr_q == ADDR_LAST) state_d = ST_DRAIN;
          else                     addr_d  = addr_q + 1'b1;
        end
        ST_DRAIN: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
    if (!i_ppu_rstn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      scan_q      <= '0;
      tall_q      <= 1'b0;
      cmp_vld_q   <= 1'b0;
      cmp_first_q <= 1'b0;
      spr0_q      <= 1'b0;
      ovfl_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      scan_q      <= scan_d;
      tall_q      <= tall_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_first_q <= cmp_first_d;
      spr0_q      <= spr0_d;
      ovfl_q      <= ovfl_d;
      done_q      <= done_d;
    end
  end

  ppu_spr_sec_oam #(
    .DEPTH (SPR_PER_LINE),
    .IW    (CW)
  ) u_sec_oam (
    .i_ppu_clk  (i_ppu_clk),
    .i_ppu_rstn (i_ppu_rstn),
    .i_wr_en    (wr_en),
    .i_wr_idx   (cnt_q),
    .i_wr_dat   (wr_dat),
    .i_rd_idx   (i_sec_idx),
    .o_rd_dat   (o_sec_rdata)
  );

  assign o_oam_addr  = addr_q;
  assign o_sec_cnt   = cnt_q;
  assign o_eval_busy = (state_q != ST_IDLE);
  assign o_eval_done = done_q;
  assign o_spr0_line = spr0_q;
  assign o_spr_ovfl  = ovfl_q;

endmodule

// File: tb/tb_ppu_spr_eval.sv
// Scoreboard bench: two evaluators (8 and 16 sprites per line) share one OAM image and stimulus;
// expectations come from a plain range-test model and are checked when each done pulse appears.
module tb_ppu_spr_eval;

  typedef struct packed {
    logic [4:0]        cnt;
    logic              spr0;
    logic              ovfl;
    logic [31:0]       done_cyc;
    logic [15:0][31:0] slot;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_start, tall, clr;
  logic [7:0]  scanline;
  logic [5:0]  addr_a, addr_b;
  logic [31:0] rd_a, rd_b, srd_a, srd_b;
  logic [3:0]  sidx_a, cnt_a;
  logic [4:0]  sidx_b, cnt_b;
  logic        busy_a, done_a, spr0_a, ovfl_a;
  logic        busy_b, done_b, spr0_b, ovfl_b;

  logic [31:0] oam [64];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  bit          movfl[2];
  bit          prev_ovfl[2];
  logic [7:0]  last_s;
  bit          last_t;

  ppu_spr_eval u_dut8 (
    .i_ppu_clk(clk), .i_ppu_rstn(rst_n), .i_line_start(line_start), .i_scanline(scanline),
    .i_spr_8x16(tall), .i_ovfl_clr(clr), .o_oam_addr(addr_a), .i_oam_rdata(rd_a),
    .i_sec_idx(sidx_a), .o_sec_rdata(srd_a), .o_sec_cnt(cnt_a), .o_eval_busy(busy_a),
    .o_eval_done(done_a), .o_spr0_line(spr0_a), .o_spr_ovfl(ovfl_a)
  );

  ppu_spr_eval #(.SPR_PER_LINE(16), .CW(5)) u_dut16 (
    .i_ppu_clk(clk), .i_ppu_rstn(rst_n), .i_line_start(line_start), .i_scanline(scanline),
    .i_spr_8x16(tall), .i_ovfl_clr(clr), .o_oam_addr(addr_b), .i_oam_rdata(rd_b),
    .i_sec_idx(sidx_b), .o_sec_rdata(srd_b), .o_sec_cnt(cnt_b), .o_eval_busy(busy_b),
    .o_eval_done(done_b), .o_spr0_line(spr0_b), .o_spr_ovfl(ovfl_b)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rd_a <= oam[addr_a];
    rd_b <= oam[addr_b];
  end

  function automatic int lim(input int d);
    return (d == 0) ? 8 : 16;
  endfunction

  function automatic bit inr(input int s, input int y, input bit t);
    return (s >= y) && ((s - y) < (t ? 16 : 8));
  endfunction

  function automatic exp_t model(input logic [7:0] s, input bit t, input int l, input bit ovfl_in);
    exp_t e;
    int   found = 0;
    e = '0;
    for (int n = 0; n < 64; n++) begin
      if (inr(int'(s), int'(oam[n][7:0]), t)) begin
        if (n == 0) e.spr0 = 1'b1;
        if (found < l) e.slot[found] = {oam[n][31:8], 4'b0000, 4'(int'(s) - int'(oam[n][7:0]))};
        found++;
      end
    end
    e.cnt  = 5'((found < l) ? found : l);
    e.ovfl = ovfl_in || (found > l);
    return e;
  endfunction

  // Overflow raised by a scan aborted on edge k: only entries 0..k-2 were compared by then.
  function automatic bit partial_ovfl(input logic [7:0] s, input bit t, input int l, input int k);
    int found = 0;
    for (int n = 0; n <= k - 2 && n < 64; n++)
      if (inr(int'(s), int'(oam[n][7:0]), t)) found++;
    return found > l;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic [4:0] c, input logic s0, input logic ov, input int at);
    exp_t  e;
    string tag = (d == 0) ? "dut8" : "dut16";
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected_done actual=1 required=0 cycle=%0d", tag, at);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    chk({tag, " cnt"}, 64'(c), 64'(e.cnt));
    chk({tag, " spr0_line"}, 64'(s0), 64'(e.spr0));
    chk({tag, " ovfl"}, 64'(ov), 64'(e.ovfl));
    chk({tag, " done_cycle"}, 64'(at), 64'(e.done_cyc));
    for (int i = 0; i < int'(e.cnt); i++) begin
      if (d == 0) sidx_a = 4'(i); else sidx_b = 5'(i);
      #1;
      chk($sformatf("%s slot%0d", tag, i), 64'((d == 0) ? srd_a : srd_b), 64'(e.slot[i]));
    end
    if (d == 0) sidx_a = 4'(lim(0)); else sidx_b = 5'(lim(1));
    #1;
    chk({tag, " slot_out_of_range"}, 64'((d == 0) ? srd_a : srd_b), 64'd0);
  endtask

  initial begin : monitor
    logic       da, db, s0a, s0b, ova, ovb;
    logic [4:0] ca, cb;
    int         at;
    sidx_a = '0;
    sidx_b = '0;
    forever begin
      @(negedge clk);
      da = done_a; db = done_b; at = cyc;
      ca = {1'b0, cnt_a}; s0a = spr0_a; ova = ovfl_a;
      cb = cnt_b;         s0b = spr0_b; ovb = ovfl_b;
      if (da) check_dut(0, ca, s0a, ova, at);
      if (db) check_dut(1, cb, s0b, ovb, at);
    end
  end

  task automatic do_scan(input logic [7:0] s, input bit t, input bit c);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      prev_ovfl[d] = movfl[d];
      e = model(s, t, lim(d), movfl[d]);
      movfl[d] = e.ovfl;
      e.done_cyc = 32'(cyc + 66);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    line_start = 1'b1; scanline = s; tall = t; clr = c;
    @(negedge clk);
    line_start = 1'b0; clr = 1'b0;
    last_s = s; last_t = t;
  endtask

  task automatic abort_scan(input int k, input logic [7:0] s, input bit t, input bit c);
    repeat (k - 1) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) void'(q0.pop_back()); else void'(q1.pop_back());
      if (partial_ovfl(last_s, last_t, lim(d), k)) movfl[d] = 1'b1;
      else if (c)                                  movfl[d] = 1'b0;
      else                                         movfl[d] = prev_ovfl[d];
    end
    do_scan(s, t, c);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=pending%0d required=0", q0.size() + q1.size());
      q0.delete();
      q1.delete();
    end
    repeat (8) @(negedge clk);
    chk("busy_after_done8", 64'(busy_a), 64'd0);
    chk("busy_after_done16", 64'(busy_b), 64'd0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    movfl[0] = 1'b0;
    movfl[1] = 1'b0;
    chk("ovfl_clear8", 64'(ovfl_a), 64'd0);
    chk("ovfl_clear16", 64'(ovfl_b), 64'd0);
  endtask

  task automatic fill(input logic [7:0] y);
    logic [31:0] w;
    for (int n = 0; n < 64; n++) begin
      w = $urandom();
      oam[n] = {w[31:8], y};
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, " busy8"}, 64'(busy_a), 64'd0);
    chk({nm, " done8"}, 64'(done_a), 64'd0);
    chk({nm, " cnt8"}, 64'(cnt_a), 64'd0);
    chk({nm, " spr0_8"}, 64'(spr0_a), 64'd0);
    chk({nm, " ovfl8"}, 64'(ovfl_a), 64'd0);
    chk({nm, " addr8"}, 64'(addr_a), 64'd0);
    chk({nm, " sec8"}, 64'(srd_a), 64'd0);
    chk({nm, " busy16"}, 64'(busy_b), 64'd0);
    chk({nm, " cnt16"}, 64'(cnt_b), 64'd0);
    chk({nm, " ovfl16"}, 64'(ovfl_b), 64'd0);
    chk({nm, " addr16"}, 64'(addr_b), 64'd0);
  endtask

  initial begin : timeout
    #800000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0]  s, y;
    logic [31:0] w;
    bit          t;
    rst_n = 1'b0; line_start = 1'b0; tall = 1'b0; clr = 1'b0; scanline = '0;
    movfl[0] = 1'b0; movfl[1] = 1'b0;
    fill(8'hF0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("post_reset");

    // Four sprites at Y=0x10 seen on line 0x12.
    for (int n = 0; n < 4; n++) oam[n][7:0] = 8'h10;
    do_scan(8'h12, 1'b0, 1'b0);
    chk("busy_in_scan", 64'(busy_a), 64'd1);
    wait_done();

    // Ten sprites on one line, then overflow set racing a clear and a restart.
    fill(8'hF0);
    for (int n = 0; n < 10; n++) oam[n][7:0] = 8'h20;
    do_scan(8'h27, 1'b0, 1'b0);
    wait_done();
    pulse_clr();
    do_scan(8'h27, 1'b0, 1'b0);
    abort_scan(10, 8'h80, 1'b0, 1'b1);
    wait_done();

    // 8x16 height boundaries.
    fill(8'hF0);
    oam[0][7:0] = 8'h30;
    do_scan(8'h3F, 1'b1, 1'b0); wait_done();
    do_scan(8'h40, 1'b1, 1'b0); wait_done();
    do_scan(8'h38, 1'b0, 1'b0); wait_done();

    // No wrap for Y=0xFF; Y=0 on line 0.
    fill(8'hFF);
    do_scan(8'h03, 1'b0, 1'b0); wait_done();
    oam[1][7:0] = 8'h00;
    do_scan(8'h00, 1'b0, 1'b0); wait_done();

    // Restart mid-scan: only the second line's result is reported.
    fill(8'hF0);
    for (int n = 0; n < 4; n++) oam[n][7:0] = 8'h10;
    for (int n = 40; n < 46; n++) oam[n][7:0] = 8'h60;
    do_scan(8'h60, 1'b0, 1'b0);
    abort_scan(30, 8'h12, 1'b0, 1'b0);
    wait_done();

    // Asynchronous reset during a scan.
    do_scan(8'h60, 1'b0, 1'b0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("mid_scan_reset");
    void'(q0.pop_back());
    void'(q1.pop_back());
    movfl[0] = 1'b0; movfl[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("no_done_after_reset", 64'(cnt_a), 64'd0);

    // Twelve in range: fits the 16-slot build, overflows the 8-slot one.
    pulse_clr();
    fill(8'hF0);
    for (int n = 3; n < 15; n++) oam[n][7:0] = 8'h50;
    do_scan(8'h55, 1'b0, 1'b0); wait_done();

    for (int it = 0; it < 12; it++) begin
      s = 8'($urandom_range(0, 255));
      t = 1'($urandom_range(0, 1));
      for (int n = 0; n < 64; n++) begin
        w = $urandom();
        y = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(s - 8'($urandom_range(0, 18)));
        oam[n] = {w[31:8], y};
      end
      if ($urandom_range(0, 2) == 0) pulse_clr();
      do_scan(s, t, 1'b0);
      wait_done();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
